// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and helpers for the serial sequence detectors
package seq_det_pkg;

    localparam logic [3:0] SEQ_1011 = 4'b1011;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;
    localparam int CNT_W_MIN = 2;

    // Width of a fill counter that must hold 0..pat_w inclusive.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with all-ones flag
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    assign sat = &count;

    always_ff @(posedge clk) begin
        if (res) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised Moore serial pattern detector with match counter
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = SEQ_1011,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             a,
    input  logic             valid,
    input  logic             overlap_en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int               FILL_W    = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
        $error("seq_detect_param: PAT_W out of range");
    end
    if (CNT_W < CNT_W_MIN) begin : g_bad_cnt_w
        $error("seq_detect_param: CNT_W too small");
    end

    logic [PAT_W-1:0]  pat_reg;
    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  hist_nxt;
    logic [FILL_W-1:0] fill_nxt;
    logic              y_nxt;
    logic              accept;

    assign accept = valid && !pat_load;
    assign y      = (fill == FILL_FULL) && (hist == pat_reg);

    // Next state for an accepted bit; in non-overlap mode a match restarts the window.
    always_comb begin
        hist_nxt = {hist[PAT_W-2:0], a};
        fill_nxt = fill;
        if (!overlap_en && y) begin
            fill_nxt = FILL_W'(1);
        end else if (fill != FILL_FULL) begin
            fill_nxt = fill + FILL_W'(1);
        end
        y_nxt = (fill_nxt == FILL_FULL) && (hist_nxt == pat_reg);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            pat_reg <= PAT_RST;
            hist    <= '0;
            fill    <= '0;
        end else if (pat_load) begin
            pat_reg <= pat_in;
            hist    <= '0;
            fill    <= '0;
        end else if (valid) begin
            hist <= hist_nxt;
            fill <= fill_nxt;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .res   (res),
        .inc   (accept && y_nxt),
        .count (match_cnt),
        .sat   (cnt_sat)
    );

endmodule
